// File: rtl/aes_arb_ctrl.sv
// aes_arb_ctrl: two-port round-robin arbiter and load sequencer for a single AES_CH core.
// Skips the key load when the requested {key, mode} already sits in the core; a watchdog aborts hung jobs.
module aes_arb_ctrl #(
   parameter int TIMEOUT = 31,
   parameter int CW      = 5
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         r0_valid,
   output logic         r0_ready,
   input  logic [127:0] r0_key,
   input  logic [127:0] r0_din,
   input  logic         r0_mode,
   output logic         r0_resp_valid,
   input  logic         r0_resp_ready,
   output logic         r0_resp_err,
   input  logic         r1_valid,
   output logic         r1_ready,
   input  logic [127:0] r1_key,
   input  logic [127:0] r1_din,
   input  logic         r1_mode,
   output logic         r1_resp_valid,
   input  logic         r1_resp_ready,
   output logic         r1_resp_err,
   output logic [127:0] resp_dout,
   output logic [127:0] core_din,
   output logic [127:0] core_key,
   output logic         core_drdy,
   output logic         core_krdy,
   output logic         core_en,
   output logic         core_mode,
   input  logic [127:0] core_dout,
   input  logic         core_bsy,
   input  logic         core_dvld,
   output logic         busy
);

   typedef enum logic [2:0] {IDLE, KEY, KWAIT, DATA, WAIT, RESP} state_t;

   state_t        state_reg, state_next;
   logic [CW-1:0] wd_reg;
   logic          last_grant_reg, grant_reg;
   logic          cache_vld_reg, cache_mode_reg;
   logic [127:0]  cache_key_reg;
   logic [127:0]  core_din_reg, core_key_reg, resp_dout_reg;
   logic          core_mode_reg, core_drdy_reg, core_krdy_reg, core_en_reg, busy_reg;
   logic          err_reg, err_next;

   logic          sel, grant_now, hit, take, timeout, key_done, done, wd_expired;
   logic [127:0]  sel_key, sel_din;
   logic          sel_mode;
   logic [1:0]    resp_ready_vec, ready_vec, resp_valid_vec, resp_err_vec;

   // On a tie the requester that did not win last time is chosen.
   assign sel      = r0_valid ? (r1_valid & ~last_grant_reg) : 1'b1;
   assign sel_key  = sel ? r1_key  : r0_key;
   assign sel_din  = sel ? r1_din  : r0_din;
   assign sel_mode = sel ? r1_mode : r0_mode;
   assign hit      = cache_vld_reg && (cache_key_reg == sel_key) && (cache_mode_reg == sel_mode);

   assign wd_expired     = (wd_reg == CW'(TIMEOUT - 1));
   assign resp_ready_vec = {r1_resp_ready, r0_resp_ready};
   assign err_next       = timeout | (err_reg & ~done);

   always_comb begin
      state_next = state_reg;
      grant_now  = 1'b0;
      take       = 1'b0;
      timeout    = 1'b0;
      key_done   = 1'b0;
      done       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (r0_valid || r1_valid) begin
               grant_now  = 1'b1;
               state_next = hit ? DATA : KEY;
            end
         end
         KEY: state_next = KWAIT;
         KWAIT: begin
            if (!core_bsy) begin
               key_done   = 1'b1;
               state_next = DATA;
            end else if (wd_expired) begin
               timeout    = 1'b1;
               state_next = RESP;
            end
         end
         // A core answering while Datardy is still high is accepted here.
         DATA: begin
            if (core_dvld) begin
               take       = 1'b1;
               state_next = RESP;
            end else begin
               state_next = WAIT;
            end
         end
         WAIT: begin
            if (core_dvld) begin
               take       = 1'b1;
               state_next = RESP;
            end else if (wd_expired) begin
               timeout    = 1'b1;
               state_next = RESP;
            end
         end
         RESP: begin
            if (resp_ready_vec[grant_reg]) begin
               done       = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_reg      <= IDLE;
         wd_reg         <= '0;
         last_grant_reg <= 1'b1;
         grant_reg      <= 1'b0;
         cache_vld_reg  <= 1'b0;
         cache_key_reg  <= '0;
         cache_mode_reg <= 1'b0;
         core_din_reg   <= '0;
         core_key_reg   <= '0;
         core_mode_reg  <= 1'b0;
         core_drdy_reg  <= 1'b0;
         core_krdy_reg  <= 1'b0;
         core_en_reg    <= 1'b0;
         busy_reg       <= 1'b0;
         resp_dout_reg  <= '0;
         err_reg        <= 1'b0;
      end else begin
         state_reg     <= state_next;
         core_en_reg   <= 1'b1;
         core_krdy_reg <= (state_next == KEY);
         core_drdy_reg <= (state_next == DATA);
         busy_reg      <= (state_next != IDLE);
         err_reg       <= err_next;
         if ((state_next == KWAIT || state_next == WAIT) && state_next != state_reg)
            wd_reg <= '0;
         else if (state_reg == KWAIT || state_reg == WAIT)
            wd_reg <= wd_reg + CW'(1);
         if (grant_now) begin
            grant_reg     <= sel;
            core_key_reg  <= sel_key;
            core_din_reg  <= sel_din;
            core_mode_reg <= sel_mode;
         end
         if (key_done) begin
            cache_vld_reg  <= 1'b1;
            cache_key_reg  <= core_key_reg;
            cache_mode_reg <= core_mode_reg;
         end else if (timeout) begin
            cache_vld_reg  <= 1'b0;
         end
         if (take)
            resp_dout_reg <= core_dout;
         else if (timeout)
            resp_dout_reg <= '0;
         if (done)
            last_grant_reg <= grant_reg;
      end
   end

   // Per-requester handshake outputs, all registered.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_req
         logic ready_reg, resp_valid_reg, resp_err_reg;
         always_ff @(posedge CLK or negedge RST) begin
            if (!RST) begin
               ready_reg      <= 1'b0;
               resp_valid_reg <= 1'b0;
               resp_err_reg   <= 1'b0;
            end else begin
               ready_reg      <= grant_now && (sel == 1'(gi));
               resp_valid_reg <= (state_next == RESP) && (grant_reg == 1'(gi));
               resp_err_reg   <= (state_next == RESP) && (grant_reg == 1'(gi)) && err_next;
            end
         end
         assign ready_vec[gi]      = ready_reg;
         assign resp_valid_vec[gi] = resp_valid_reg;
         assign resp_err_vec[gi]   = resp_err_reg;
      end
   endgenerate

   assign r0_ready      = ready_vec[0];
   assign r1_ready      = ready_vec[1];
   assign r0_resp_valid = resp_valid_vec[0];
   assign r1_resp_valid = resp_valid_vec[1];
   assign r0_resp_err   = resp_err_vec[0];
   assign r1_resp_err   = resp_err_vec[1];
   assign resp_dout     = resp_dout_reg;
   assign core_din      = core_din_reg;
   assign core_key      = core_key_reg;
   assign core_mode     = core_mode_reg;
   assign core_drdy     = core_drdy_reg;
   assign core_krdy     = core_krdy_reg;
   assign core_en       = core_en_reg;
   assign busy          = busy_reg;

endmodule

// File: tb/tb_aes_arb_ctrl.sv
// Directed bench for aes_arb_ctrl with a behavioural AES_CH stand-in (known vectors, XOR otherwise).
module tb_aes_arb_ctrl;
   localparam int TIMEOUT = 31;
   localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] K1 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
   localparam logic [127:0] KA = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] DA = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] KB = 128'hfedcba9876543210f0e1d2c3b4a59687;
   localparam logic [127:0] DB = 128'h0123456789abcdef1122334455667788;
   localparam logic [127:0] KT = 128'hdeadbeef00000000cafef00d12345678;
   localparam logic [127:0] DT = 128'h5555aaaa5555aaaa0f0f0f0ff0f0f0f0;

   logic CLK, RST;
   logic r0_valid, r0_ready, r0_mode, r0_resp_valid, r0_resp_ready, r0_resp_err;
   logic r1_valid, r1_ready, r1_mode, r1_resp_valid, r1_resp_ready, r1_resp_err;
   logic [127:0] r0_key, r0_din, r1_key, r1_din, resp_dout;
   logic [127:0] core_din, core_key, core_dout;
   logic core_drdy, core_krdy, core_en, core_mode, core_bsy, core_dvld, busy;
   logic [394:0] all_out;

   int vec, miscmp;
   int krdy_cnt;
   int kbusy, lat;
   bit hang;

   aes_arb_ctrl #(.TIMEOUT(TIMEOUT), .CW(5)) dut (
      .CLK(CLK), .RST(RST),
      .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_key(r0_key), .r0_din(r0_din), .r0_mode(r0_mode),
      .r0_resp_valid(r0_resp_valid), .r0_resp_ready(r0_resp_ready), .r0_resp_err(r0_resp_err),
      .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_key(r1_key), .r1_din(r1_din), .r1_mode(r1_mode),
      .r1_resp_valid(r1_resp_valid), .r1_resp_ready(r1_resp_ready), .r1_resp_err(r1_resp_err),
      .resp_dout(resp_dout), .core_din(core_din), .core_key(core_key), .core_drdy(core_drdy),
      .core_krdy(core_krdy), .core_en(core_en), .core_mode(core_mode), .core_dout(core_dout),
      .core_bsy(core_bsy), .core_dvld(core_dvld), .busy(busy)
   );

   assign all_out = {r0_ready, r1_ready, r0_resp_valid, r1_resp_valid, r0_resp_err, r1_resp_err,
                     resp_dout, core_din, core_key, core_drdy, core_krdy, core_en, core_mode, busy};

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [127:0] aes_model(input logic [127:0] k, input logic [127:0] d, input logic m);
      if (k == K0 && d == P0 && !m) return C0;
      if (k == K1 && d == C0 && m) return P0;
      return k ^ d ^ {128{m}};
   endfunction

   // Core stand-in: busy for kbusy cycles after a key load, answers lat cycles after a data load.
   logic [127:0] stub_key, stub_res;
   int bsy_left, lat_left;
   bit pending;
   always @(posedge CLK or negedge RST) begin
      if (!RST) begin
         core_bsy <= 1'b0; core_dvld <= 1'b0; core_dout <= '0;
         bsy_left <= 0; lat_left <= 0; pending <= 1'b0;
      end else begin
         core_dvld <= 1'b0;
         if (core_krdy) begin
            stub_key <= core_key; bsy_left <= kbusy; core_bsy <= (kbusy != 0);
         end else if (bsy_left > 0) begin
            bsy_left <= bsy_left - 1; core_bsy <= (bsy_left > 1);
         end
         if (core_drdy && !hang) begin
            pending <= 1'b1; lat_left <= lat; stub_res <= aes_model(stub_key, core_din, core_mode);
         end else if (pending) begin
            if (lat_left <= 1) begin
               core_dvld <= 1'b1; core_dout <= stub_res; pending <= 1'b0;
            end else begin
               lat_left <= lat_left - 1;
            end
         end
      end
   end

   initial krdy_cnt = 0;
   always @(posedge CLK) if (core_krdy) krdy_cnt <= krdy_cnt + 1;

   task automatic pulse_reset;
      @(posedge CLK); #1 RST = 1'b0;
      @(posedge CLK); @(posedge CLK); #1 RST = 1'b1;
   endtask

   // Submits one job and waits (bounded) for its response; response is accepted immediately.
   task automatic do_job(input bit req, input logic [127:0] k, input logic [127:0] d, input logic m,
                         output bit ok, output logic [127:0] dout, output logic err,
                         output bit other_vld, output int gnt_t, output int drdy_t);
      bit granted;
      ok = 0; granted = 0; other_vld = 0; dout = '0; err = 0; gnt_t = -1; drdy_t = -1;
      if (!req) begin r0_key = k; r0_din = d; r0_mode = m; r0_valid = 1; r0_resp_ready = 1; end
      else      begin r1_key = k; r1_din = d; r1_mode = m; r1_valid = 1; r1_resp_ready = 1; end
      for (int t = 1; t <= 200 && !ok; t++) begin
         @(posedge CLK); #1;
         if (!granted && (req ? r1_ready : r0_ready)) begin
            granted = 1; gnt_t = t;
            if (!req) r0_valid = 0; else r1_valid = 0;
         end
         if (core_drdy && drdy_t < 0) drdy_t = t;
         if (req ? r1_resp_valid : r0_resp_valid) begin
            ok = 1; dout = resp_dout; err = req ? r1_resp_err : r0_resp_err;
            other_vld = req ? r0_resp_valid : r1_resp_valid;
         end
      end
      r0_valid = 0; r1_valid = 0;
      @(posedge CLK); #1;
   endtask

   task automatic test_reset;
      logic [394:0] exp_out;
      #3;
      vec++; if (all_out !== '0) begin miscmp++; $display("FAIL reset_outputs got %h want 0", all_out); end
      @(posedge CLK); @(posedge CLK); #1;
      vec++; if (core_en !== 1'b0) begin miscmp++; $display("FAIL reset_core_en_held got %b want 0", core_en); end
      RST = 1'b1;
      @(posedge CLK); #1;
      exp_out = '0; exp_out[2] = 1'b1;
      vec++; if (all_out !== exp_out) begin miscmp++; $display("FAIL post_reset_outputs got %h want %h", all_out, exp_out); end
      @(posedge CLK); #1;
      vec++; if (core_en !== 1'b1) begin miscmp++; $display("FAIL core_en_stays got %b want 1", core_en); end
   endtask

   task automatic test_cache_miss;
      bit ok, oth; logic [127:0] dout; logic err; int g, d, k0;
      k0 = krdy_cnt;
      do_job(1'b0, K0, P0, 1'b0, ok, dout, err, oth, g, d);
      vec++; if (!ok) begin miscmp++; $display("FAIL miss_resp_seen got 0 want 1"); end
      vec++; if (dout !== C0) begin miscmp++; $display("FAIL miss_dout got %h want %h", dout, C0); end
      vec++; if (err !== 1'b0) begin miscmp++; $display("FAIL miss_err got %b want 0", err); end
      vec++; if (krdy_cnt - k0 != 1) begin miscmp++; $display("FAIL miss_krdy_pulses got %0d want 1", krdy_cnt - k0); end
      vec++; if (oth !== 1'b0) begin miscmp++; $display("FAIL miss_r1_resp_valid got %b want 0", oth); end
   endtask

   task automatic test_cache_hit;
      bit ok, oth; logic [127:0] dout; logic err; int g, d, k0;
      k0 = krdy_cnt;
      do_job(1'b0, K0, P0, 1'b0, ok, dout, err, oth, g, d);
      vec++; if (krdy_cnt - k0 != 0) begin miscmp++; $display("FAIL hit_krdy_pulses got %0d want 0", krdy_cnt - k0); end
      vec++; if (d != g || g < 0) begin miscmp++; $display("FAIL hit_drdy_cycle got %0d want %0d", d, g); end
      vec++; if (dout !== C0) begin miscmp++; $display("FAIL hit_dout got %h want %h", dout, C0); end
      k0 = krdy_cnt;
      do_job(1'b0, K1, C0, 1'b1, ok, dout, err, oth, g, d);
      vec++; if (krdy_cnt - k0 != 1) begin miscmp++; $display("FAIL dec_krdy_pulses got %0d want 1", krdy_cnt - k0); end
      vec++; if (dout !== P0) begin miscmp++; $display("FAIL dec_dout got %h want %h", dout, P0); end
      vec++; if (!ok || err !== 1'b0) begin miscmp++; $display("FAIL dec_resp got ok=%0b err=%b want ok=1 err=0", ok, err); end
   endtask

   task automatic test_arbitration;
      int gnt[4]; int ng, nr; logic [127:0] exp;
      pulse_reset();
      r0_key = KA; r0_din = DA; r0_mode = 0; r1_key = KB; r1_din = DB; r1_mode = 1;
      r0_resp_ready = 1; r1_resp_ready = 1; r0_valid = 1; r1_valid = 1;
      ng = 0; nr = 0;
      for (int t = 0; t < 600 && nr < 4; t++) begin
         @(posedge CLK); #1;
         if (r0_ready || r1_ready) begin
            if (ng < 4) gnt[ng] = r1_ready ? 1 : 0;
            ng++;
            if (ng >= 4) begin r0_valid = 0; r1_valid = 0; end
         end
         if ((r0_resp_valid || r1_resp_valid) && nr < ng && nr < 4) begin
            exp = gnt[nr] ? (KB ^ DB ^ {128{1'b1}}) : (KA ^ DA);
            vec++;
            if ({r1_resp_valid, r0_resp_valid} !== (gnt[nr] ? 2'b10 : 2'b01) || resp_dout !== exp) begin
               miscmp++;
               $display("FAIL arb_resp%0d got v=%b%b dout=%h want owner r%0d dout=%h",
                        nr, r1_resp_valid, r0_resp_valid, resp_dout, gnt[nr], exp);
            end
            nr++;
         end
      end
      r0_valid = 0; r1_valid = 0;
      vec++; if (nr != 4 || ng != 4) begin miscmp++; $display("FAIL arb_job_count got grants=%0d resps=%0d want 4/4", ng, nr); end
      for (int i = 0; i < 4 && i < ng; i++) begin
         vec++; if (gnt[i] != i % 2) begin miscmp++; $display("FAIL arb_grant%0d got r%0d want r%0d", i, gnt[i], i % 2); end
      end
      @(posedge CLK); #1;
   endtask

   task automatic test_back_pressure;
      bit seen; logic [127:0] exp1;
      exp1 = KB ^ DB ^ {128{1'b1}};
      r1_key = KB; r1_din = DB; r1_mode = 1; r1_resp_ready = 0; r1_valid = 1;
      r0_key = KA; r0_din = DA; r0_mode = 0; r0_resp_ready = 1;
      seen = 0;
      for (int t = 0; t < 200 && !seen; t++) begin
         @(posedge CLK); #1;
         if (r1_ready) begin r1_valid = 0; r0_valid = 1; end
         if (r1_resp_valid) seen = 1;
      end
      vec++; if (!seen) begin miscmp++; $display("FAIL bp_resp_seen got 0 want 1"); end
      for (int t = 0; t < 20; t++) begin
         vec++;
         if (r1_resp_valid !== 1'b1 || resp_dout !== exp1 || r0_ready !== 1'b0 || r1_resp_err !== 1'b0) begin
            miscmp++;
            $display("FAIL bp_hold%0d got v=%b dout=%h r0_ready=%b err=%b want 1 %h 0 0",
                     t, r1_resp_valid, resp_dout, r0_ready, r1_resp_err, exp1);
         end
         @(posedge CLK); #1;
      end
      r1_resp_ready = 1;
      @(posedge CLK); #1;
      vec++; if (r1_resp_valid !== 1'b0 || r0_ready !== 1'b0) begin miscmp++; $display("FAIL bp_release got v=%b r0_ready=%b want 0 0", r1_resp_valid, r0_ready); end
      @(posedge CLK); #1;
      vec++; if (r0_ready !== 1'b1) begin miscmp++; $display("FAIL bp_next_grant got %b want 1", r0_ready); end
      r0_valid = 0;
      seen = 0;
      for (int t = 0; t < 200 && !seen; t++) begin
         @(posedge CLK); #1;
         if (r0_resp_valid) begin
            seen = 1;
            vec++; if (resp_dout !== (KA ^ DA)) begin miscmp++; $display("FAIL bp_r0_dout got %h want %h", resp_dout, KA ^ DA); end
         end
      end
      vec++; if (!seen) begin miscmp++; $display("FAIL bp_r0_resp_seen got 0 want 1"); end
      @(posedge CLK); #1;
   endtask

   task automatic test_timeout;
      bit ok, oth; logic [127:0] dout; logic err; int g, d, k0, d_t, r_t;
      do_job(1'b0, KT, DT, 1'b0, ok, dout, err, oth, g, d);
      hang = 1; k0 = krdy_cnt;
      r0_key = KT; r0_din = DT; r0_mode = 0; r0_resp_ready = 0; r0_valid = 1;
      d_t = -1; r_t = -1;
      for (int t = 1; t <= 200 && r_t < 0; t++) begin
         @(posedge CLK); #1;
         if (r0_ready) r0_valid = 0;
         if (core_drdy) d_t = t;
         if (r0_resp_valid) begin r_t = t; dout = resp_dout; err = r0_resp_err; end
      end
      r0_valid = 0;
      vec++; if (r_t < 0 || d_t < 0 || r_t - d_t - 1 != TIMEOUT) begin miscmp++; $display("FAIL to_latency got %0d want %0d", r_t - d_t - 1, TIMEOUT); end
      vec++; if (err !== 1'b1) begin miscmp++; $display("FAIL to_err got %b want 1", err); end
      vec++; if (dout !== '0) begin miscmp++; $display("FAIL to_dout got %h want 0", dout); end
      vec++; if (krdy_cnt - k0 != 0) begin miscmp++; $display("FAIL to_hit_krdy got %0d want 0", krdy_cnt - k0); end
      r0_resp_ready = 1;
      @(posedge CLK); #1;
      vec++; if (r0_resp_valid !== 1'b0 || r0_resp_err !== 1'b0) begin miscmp++; $display("FAIL to_clear got v=%b err=%b want 0 0", r0_resp_valid, r0_resp_err); end
      hang = 0; k0 = krdy_cnt;
      do_job(1'b0, KT, DT, 1'b0, ok, dout, err, oth, g, d);
      vec++; if (krdy_cnt - k0 != 1) begin miscmp++; $display("FAIL to_retry_krdy got %0d want 1", krdy_cnt - k0); end
      vec++; if (!ok || dout !== (KT ^ DT) || err !== 1'b0) begin miscmp++; $display("FAIL to_retry_resp got ok=%0b dout=%h err=%b want 1 %h 0", ok, dout, err, KT ^ DT); end
   endtask

   task automatic test_reset_mid_wait;
      bit ok, oth; logic [127:0] dout; logic err; int g, d, k0, d_t, nresp;
      hang = 1;
      r0_key = KT; r0_din = DT; r0_mode = 0; r0_resp_ready = 1; r0_valid = 1;
      d_t = -1;
      for (int t = 1; t <= 100 && (d_t < 0 || t <= d_t + 3); t++) begin
         @(posedge CLK); #1;
         if (r0_ready) r0_valid = 0;
         if (core_drdy && d_t < 0) d_t = t;
      end
      r0_valid = 0;
      vec++; if (d_t < 0 || busy !== 1'b1) begin miscmp++; $display("FAIL rst_setup got drdy_t=%0d busy=%b want >=0 1", d_t, busy); end
      RST = 1'b0;
      #1;
      vec++; if (all_out !== '0) begin miscmp++; $display("FAIL rst_async_outputs got %h want 0", all_out); end
      @(posedge CLK); @(posedge CLK); #1;
      RST = 1'b1;
      nresp = 0;
      for (int t = 0; t < 8; t++) begin
         @(posedge CLK); #1;
         if (r0_resp_valid || r1_resp_valid) nresp++;
      end
      vec++; if (nresp != 0) begin miscmp++; $display("FAIL rst_no_resp got %0d want 0", nresp); end
      hang = 0; k0 = krdy_cnt;
      do_job(1'b0, KT, DT, 1'b0, ok, dout, err, oth, g, d);
      vec++; if (krdy_cnt - k0 != 1) begin miscmp++; $display("FAIL rst_reload_krdy got %0d want 1", krdy_cnt - k0); end
      vec++; if (!ok || dout !== (KT ^ DT)) begin miscmp++; $display("FAIL rst_reload_dout got %h want %h", dout, KT ^ DT); end
   endtask

   initial begin
      vec = 0; miscmp = 0;
      RST = 1'b0; hang = 0; kbusy = 3; lat = 4;
      r0_valid = 0; r0_key = '0; r0_din = '0; r0_mode = 0; r0_resp_ready = 0;
      r1_valid = 0; r1_key = '0; r1_din = '0; r1_mode = 0; r1_resp_ready = 0;
      test_reset();
      test_cache_miss();
      test_cache_hit();
      test_arbitration();
      test_back_pressure();
      test_timeout();
      test_reset_mid_wait();
      $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
      $finish;
   end

endmodule
